dvs_aer_event_receiver: RTL and testbench

Parametrised successor to the single-event DVS AER receiver. Runs the same 4-phase REQ/ACK handshake with the DVS camera, but adds configurable address width, synchroniser depth and data-settle delay. Each captured {xsel, addr} word goes into an event FIFO that is drained by a valid/ready consumer. ACK is withheld while the FIFO is full, so back-pressure stalls the camera instead of losing events.

---
 rtl/dvs_aer_event_receiver.sv | 222 ++++++++++++++++++++++
 tb/tb_dvs_aer_event_receiver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvs_aer_event_receiver.sv
// DVS AER event receiver.
// Runs the 4-phase REQ/ACK handshake with a DVS camera. The req, xsel and
// aer inputs are synchronised. Each handshake pushes one {xsel, addr} word
// into an event FIFO, and a valid/ready consumer drains that FIFO. ACK is
// held low while the FIFO is full, so the camera stalls and no event is lost.
// Optional build macro AER_TIMEOUT_EN adds an ACK timeout with a sticky
// timeout_err flag. When the macro is undefined, timeout_err is tied low.
module dvs_aer_event_receiver #(
  parameter int AER_W       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AER_W-1:0]            aer,
  input  logic                        xsel,
  input  logic                        req,
  output logic                        ack,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic                        evt_xsel,
  output logic [AER_W-1:0]            evt_addr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = AER_W + 2;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] ACK     = 2'd3;

  // Synchroniser chain: element 0 is the newest sample.
  logic [SYNC_STAGES-1:0][SW-1:0] sync_reg;
  logic                           req_s;
  logic                           xsel_s;
  logic [AER_W-1:0]               aer_s;

  // FSM state
  logic [1:0] state_reg, state_next;
  logic [3:0] settle_reg, settle_next;
  logic       ack_reg;
  logic       push;
  logic       idle_ok;

  // FIFO state
  logic [AER_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] mem_cnt_reg;
  logic [CNT_W-1:0] count_reg;
  logic             head_valid_reg;
  logic [AER_W:0]   head_reg;
  logic             full;
  logic             pop;
  logic             load;

`ifdef AER_TIMEOUT_EN
  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  logic [TO_W-1:0] to_reg, to_next;
  logic            err_reg, err_next;
  logic            hold_reg, hold_next;
`else
  logic            timeout_unused;
`endif

  // Shift the asynchronous camera inputs through the synchroniser flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], req, xsel, aer};
    end
  end

  assign req_s  = sync_reg[SYNC_STAGES-1][SW-1];
  assign xsel_s = sync_reg[SYNC_STAGES-1][AER_W];
  assign aer_s  = sync_reg[SYNC_STAGES-1][AER_W-1:0];

  // Full is judged on the registered count, so a pop frees a slot one cycle later.
  assign full = (count_reg == CNT_W'(FIFO_DEPTH));

  // Handshake FSM next-state logic.
  always_comb begin
    state_next  = state_reg;
    settle_next = settle_reg;
    push        = 1'b0;
    idle_ok     = 1'b1;
`ifdef AER_TIMEOUT_EN
    to_next     = to_reg;
    err_next    = err_reg;
    hold_next   = hold_reg;
`endif
    case (state_reg)
      IDLE: begin
`ifdef AER_TIMEOUT_EN
        // After a timeout, ignore the stuck REQ until it goes low.
        idle_ok = !hold_reg;
        if (!req_s) hold_next = 1'b0;
`endif
        if (req_s && idle_ok) begin
          if (SETTLE_CYC == 0) begin
            state_next = CAPTURE;
          end else begin
            state_next  = SETTLE;
            settle_next = 4'(SETTLE_CYC - 1);
          end
        end
      end
      SETTLE: begin
        if (settle_reg == 4'd0) state_next = CAPTURE;
        else                    settle_next = settle_reg - 4'd1;
      end
      CAPTURE: begin
        if (!full) begin
          push       = 1'b1;
          state_next = ACK;
`ifdef AER_TIMEOUT_EN
          to_next    = '0;
`endif
        end
      end
      ACK: begin
        if (!req_s) begin
          state_next = IDLE;
        end
`ifdef AER_TIMEOUT_EN
        else if (to_reg == TO_W'(ACK_TIMEOUT - 1)) begin
          state_next = IDLE;
          err_next   = 1'b1;
          hold_next  = 1'b1;
        end else begin
          to_next = to_reg + 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM registers. ACK is registered, and it is high exactly while the FSM is in ACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      settle_reg <= 4'd0;
      ack_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      settle_reg <= settle_next;
      ack_reg    <= (state_next == ACK);
    end
  end

`ifdef AER_TIMEOUT_EN
  // Timeout counter, sticky error flag and stuck-REQ hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_reg   <= '0;
      err_reg  <= 1'b0;
      hold_reg <= 1'b0;
    end else begin
      to_reg   <= to_next;
      err_reg  <= err_next;
      hold_reg <= hold_next;
    end
  end

  assign timeout_err = err_reg;
`else
  assign timeout_unused = (ACK_TIMEOUT > 0);
  assign timeout_err    = 1'b0;
`endif

  assign pop  = head_valid_reg && evt_ready;
  // Refill the head whenever it is empty or being consumed this cycle.
  assign load = (mem_cnt_reg != '0) && (!head_valid_reg || pop);

  // Event storage array. It is written only and has no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {xsel_s, aer_s};
  end

  // Head register: registered read of the oldest stored entry. It holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= '0;
    end else if (load) begin
      head_reg <= mem[rd_ptr_reg];
    end
  end

  // Pointers, counts and head-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      mem_cnt_reg    <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      mem_cnt_reg <= mem_cnt_reg + CNT_W'(push) - CNT_W'(load);
      count_reg   <= count_reg + CNT_W'(push) - CNT_W'(pop);
      if (load)     head_valid_reg <= 1'b1;
      else if (pop) head_valid_reg <= 1'b0;
    end
  end

  assign ack        = ack_reg;
  assign evt_valid  = head_valid_reg;
  assign evt_xsel   = head_reg[AER_W];
  assign evt_addr   = head_reg[AER_W-1:0];
  assign fifo_count = count_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_dvs_aer_event_receiver.sv
// Testbench for dvs_aer_event_receiver. It runs directed handshake scenarios
// and then randomized traffic against a queue-based reference. The head of
// the FIFO must always equal the oldest handshake that has not been consumed.
module tb_dvs_aer_event_receiver;
  localparam int AER_W = 10;
`ifdef AER_TIMEOUT_EN
  localparam int TB_TO = 8;
`else
  localparam int TB_TO = 1023;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AER_W-1:0] aer = '0;
  logic             xsel = 1'b0;
  logic             req = 1'b0;
  logic             evt_ready = 1'b0;
  logic             ack;
  logic             evt_valid;
  logic             evt_xsel;
  logic [AER_W-1:0] evt_addr;
  logic [2:0]       fifo_count;
  logic             busy;
  logic             timeout_err;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;
  int pop_idx = 0;
  logic [AER_W:0] sent [$];

  dvs_aer_event_receiver #(
    .AER_W(AER_W), .SYNC_STAGES(2), .SETTLE_CYC(1), .FIFO_DEPTH(4), .ACK_TIMEOUT(TB_TO)
  ) dut (
    .clk(clk), .rst(rst), .aer(aer), .xsel(xsel), .req(req), .ack(ack),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_xsel(evt_xsel),
    .evt_addr(evt_addr), .fifo_count(fifo_count), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // The monitor runs on the falling edge. The head must be the oldest
  // unconsumed handshake, and a valid&&ready head is consumed.
  always @(negedge clk) begin
    if (!mon_en) begin
      pop_idx = 0;
    end else if (evt_valid) begin
      if (pop_idx < sent.size()) check("head", {evt_xsel, evt_addr}, sent[pop_idx]);
      else check("head_extra", pop_idx, sent.size());
      if (evt_ready) pop_idx++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) evt_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic hs_begin(input logic [AER_W-1:0] a, input logic x);
    aer = a;
    xsel = x;
    req = 1'b1;
    sent.push_back({x, a});
    $display("evt %0d: xsel=%0d addr=%03h", sent.size(), x, a);
  endtask

  task automatic wait_ack(input logic lvl, input int max_cyc, output int n);
    n = 0;
    while (ack !== lvl && n < max_cyc) begin
      step();
      n++;
    end
    if (ack !== lvl) check("ack_wait", ack, lvl);
  endtask

  task automatic hs_full(input logic [AER_W-1:0] a, input logic x);
    int n;
    hs_begin(a, x);
    wait_ack(1'b1, 200, n);
    check("hs_count", fifo_count, sent.size() - pop_idx);
    req = 1'b0;
    wait_ack(1'b0, 20, n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    evt_ready = 1'b1;
    while (fifo_count != 0 && k < 64) begin
      step();
      k++;
    end
    evt_ready = 1'b0;
    check("drain", fifo_count, 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rand_ready = 1'b0;
    req = 1'b0;
    evt_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sent.delete();
    step();
    mon_en = 1'b1;
  endtask

  initial begin
    int n;
    int drop;

    // Check the reset state while rst is still asserted.
    step();
    step();
    check("rst_ack", ack, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_head", {evt_xsel, evt_addr}, 0);

    // Single event: latency, head contents, release timing.
    do_reset();
    hs_begin(10'h2A5, 1'b1);
    wait_ack(1'b1, 20, n);
    check("t1_ack_latency", n, 5);
    check("t1_valid_early", evt_valid, 0);
    step();
    check("t1_valid", evt_valid, 1);
    check("t1_addr", evt_addr, 10'h2A5);
    check("t1_xsel", evt_xsel, 1);
    check("t1_count", fifo_count, 1);
    req = 1'b0;
    step();
    step();
    check("t1_ack_hold", ack, 1);
    step();
    step();
    check("t1_ack_fall", ack, 0);
    check("t1_busy", busy, 0);
    drain();

    // Back-pressure: the fifth handshake stalls until one slot is freed.
    do_reset();
    repeat (4) hs_full(AER_W'($urandom), 1'($urandom));
    hs_begin(AER_W'($urandom), 1'($urandom));
    repeat (20) step();
    check("t2_stall_ack", ack, 0);
    check("t2_stall_count", fifo_count, 4);
    check("t2_stall_busy", busy, 1);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    wait_ack(1'b1, 10, n);
    check("t2_resume_count", fifo_count, 4);
    req = 1'b0;
    wait_ack(1'b0, 20, n);
    drain();
    check("t2_popped", pop_idx, 5);

`ifdef AER_TIMEOUT_EN
    // ACK timeout: REQ stuck high.
    do_reset();
    hs_begin(10'h0F0, 1'b0);
    wait_ack(1'b1, 20, n);
    drop = 0;
    while (ack && drop < 40) begin
      step();
      drop++;
    end
    check("to_ack_len", drop, TB_TO);
    check("to_err", timeout_err, 1);
    repeat (20) step();
    check("to_no_recap_ack", ack, 0);
    check("to_no_recap_busy", busy, 0);
    check("to_no_recap_count", fifo_count, 1);
    req = 1'b0;
    repeat (5) step();
    hs_full(10'h10F, 1'b1);
    check("to_sticky", timeout_err, 1);
    drain();
    do_reset();
    check("to_cleared", timeout_err, 0);
`else
    // Long REQ: exactly one push, ACK stays high throughout.
    do_reset();
    hs_begin(10'h0F0, 1'b0);
    wait_ack(1'b1, 20, n);
    drop = 0;
    repeat (50) begin
      step();
      if (!ack) drop++;
    end
    check("t3_ack_held", drop, 0);
    check("t3_count", fifo_count, 1);
    req = 1'b0;
    wait_ack(1'b0, 20, n);
    repeat (3) step();
    check("t3_no_dup", fifo_count, 1);
    drain();
`endif

    // Simultaneous push and pop at count 2.
    do_reset();
    hs_full(10'h111, 1'b0);
    hs_full(10'h222, 1'b1);
    step();
    check("t4_pre_count", fifo_count, 2);
    hs_begin(10'h333, 1'b0);
    repeat (4) step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("t4_ack", ack, 1);
    check("t4_count", fifo_count, 2);
    check("t4_valid", evt_valid, 1);
    check("t4_head", {evt_xsel, evt_addr}, 11'h622);
    req = 1'b0;
    wait_ack(1'b0, 20, n);
    drain();

    // Reset in the middle of a handshake.
    do_reset();
    hs_begin(10'h3C3, 1'b1);
    wait_ack(1'b1, 20, n);
    mon_en = 1'b0;
    rst = 1'b1;
    req = 1'b0;
    step();
    check("t5_ack", ack, 0);
    check("t5_valid", evt_valid, 0);
    check("t5_count", fifo_count, 0);
    check("t5_busy", busy, 0);
    rst = 1'b0;
    sent.delete();
    step();
    mon_en = 1'b1;
    hs_full(10'h155, 1'b0);
    step();
    check("t5_after_valid", evt_valid, 1);
    check("t5_after_addr", evt_addr, 10'h155);
    drain();

    // Randomized traffic with a random consumer.
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) step();
      hs_full(AER_W'($urandom), 1'($urandom));
    end
    rand_ready = 1'b0;
    drain();
    check("rand_popped", pop_idx, 40);
    check("final_valid", evt_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
